// File: rtl/l2048_pkg.sv
// Shared types and helpers for the 2048 board engine: tile geometry,
// move directions, FSM states and the gather/scatter cell mapping.
package l2048_pkg;

    localparam int TILE_W  = 4;
    localparam int N_CELLS = 16;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        SEED0 = 3'd0,
        SEED1 = 3'd1,
        IDLE  = 3'd2,
        LINE  = 3'd3,
        SPAWN = 3'd4
    } state_t;

    // Slot 0 is the end the tiles slide toward; cell = row*4 + col.
    function automatic logic [3:0] cell_idx(input dir_t dir, input logic [1:0] line,
                                            input logic [1:0] slot);
        case (dir)
            LEFT:    cell_idx = {line, slot};
            RIGHT:   cell_idx = {line, ~slot};
            UP:      cell_idx = {slot, line};
            DOWN:    cell_idx = {~slot, line};
            default: cell_idx = {line, slot};
        endcase
    endfunction

endpackage

// File: rtl/logic2048_board_move_if.sv
// Move request / board status bundle between the direction decoder,
// the board engine and the display renderer.
interface logic2048_board_move_if;
    import l2048_pkg::*;

    logic                        move_valid;
    logic [1:0]                  move_dir;
    logic [7:0]                  rnd;
    logic [N_CELLS*TILE_W-1:0]   board;
    logic                        busy;
    logic                        move_done;
    logic                        moved;

    modport master (
        output move_valid, move_dir, rnd,
        input  board, busy, move_done, moved
    );

    modport slave (
        input  move_valid, move_dir, rnd,
        output board, busy, move_done, moved
    );

endinterface

// File: rtl/l2048_spawn_picker.sv
// Finds the first empty cell scanning upward from a start index, wrapping
// from 15 back to 0.
module l2048_spawn_picker
    import l2048_pkg::*;
(
    input  logic [N_CELLS*TILE_W-1:0] board,
    input  logic [3:0]                start,
    output logic                      found,
    output logic [3:0]                idx
);

    logic [TILE_W-1:0] cells_s [0:N_CELLS-1];

    // Unpack the flat board into cells.
    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            cells_s[i] = board[i*TILE_W +: TILE_W];
        end
    end

    // Scan from the far end down so the nearest empty cell wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int j = N_CELLS - 1; j >= 0; j--) begin
            if (cells_s[start + 4'(j)] == {TILE_W{1'b0}}) begin
                found = 1'b1;
                idx   = start + 4'(j);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/logic2048SingleLine.sv
// Single-line 2048 merger: slides non-empty tiles toward slot 0 and merges
// each equal adjacent pair once, saturating the exponent at its maximum.
module logic2048SingleLine
    import l2048_pkg::*;
(
    input  logic [TILE_W-1:0] x0,
    input  logic [TILE_W-1:0] x1,
    input  logic [TILE_W-1:0] x2,
    input  logic [TILE_W-1:0] x3,
    output logic [TILE_W-1:0] y0,
    output logic [TILE_W-1:0] y1,
    output logic [TILE_W-1:0] y2,
    output logic [TILE_W-1:0] y3
);

    logic [TILE_W-1:0] xin_s  [0:3];
    logic [TILE_W-1:0] comp_s [0:7];
    logic [TILE_W-1:0] yout_s [0:3];
    logic [2:0]        cnt_s;
    logic [1:0]        oidx_s;
    logic              skip_s;

    function automatic logic [TILE_W-1:0] sat_inc(input logic [TILE_W-1:0] v);
        if (v == {TILE_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(TILE_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign xin_s[0] = x0;
    assign xin_s[1] = x1;
    assign xin_s[2] = x2;
    assign xin_s[3] = x3;

    // Compact then merge; comp_s is oversized so comp_s[i+1] stays in range.
    always_comb begin
        comp_s = '{default: {TILE_W{1'b0}}};
        cnt_s  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (xin_s[i] != {TILE_W{1'b0}}) begin
                comp_s[cnt_s] = xin_s[i];
                cnt_s         = cnt_s + 3'd1;
            end else begin
                cnt_s = cnt_s;
            end
        end
        yout_s = '{default: {TILE_W{1'b0}}};
        oidx_s = 2'd0;
        skip_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip_s) begin
                skip_s = 1'b0;
            end else if ((comp_s[i] != {TILE_W{1'b0}}) && (comp_s[i] == comp_s[i+1])) begin
                yout_s[oidx_s] = sat_inc(comp_s[i]);
                oidx_s         = oidx_s + 2'd1;
                skip_s         = 1'b1;
            end else begin
                yout_s[oidx_s] = comp_s[i];
                oidx_s         = oidx_s + 2'd1;
            end
        end
    end

    assign y0 = yout_s[0];
    assign y1 = yout_s[1];
    assign y2 = yout_s[2];
    assign y3 = yout_s[3];

endmodule

// File: rtl/logic2048_board_move.sv
// 4x4 board engine: seeds two tiles, then per move runs each line through
// the merger (one per cycle) and spawns a tile if the board changed.
// Optional feature macro: L2048_FOUR_TILE_EN (spawn a "4" when rnd[7:4]==0).
module logic2048_board_move
    import l2048_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    logic2048_board_move_if.slave   bus
);

    state_t                    state_r;
    logic [1:0]                line_idx_r;
    dir_t                      dir_r;
    logic                      change_r;
    logic [TILE_W-1:0]         cells_r [0:N_CELLS-1];
    logic                      busy_r;
    logic                      move_done_r;
    logic                      moved_r;

    logic [N_CELLS*TILE_W-1:0] board_s;
    logic [3:0]                gidx_s [0:3];
    logic [TILE_W-1:0]         x_s    [0:3];
    logic [TILE_W-1:0]         y_s    [0:3];
    logic                      line_diff_s;
    logic                      found_s;
    logic [3:0]                spawn_idx_s;
    logic [TILE_W-1:0]         spawn_val_s;

    // Flatten the cell registers onto the board bus.
    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            board_s[i*TILE_W +: TILE_W] = cells_r[i];
        end
    end

    // Gather the current line in slide order.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            gidx_s[k] = cell_idx(dir_r, line_idx_r, 2'(k));
            x_s[k]    = cells_r[gidx_s[k]];
        end
    end

    logic2048SingleLine u_line (
        .x0 (x_s[0]),
        .x1 (x_s[1]),
        .x2 (x_s[2]),
        .x3 (x_s[3]),
        .y0 (y_s[0]),
        .y1 (y_s[1]),
        .y2 (y_s[2]),
        .y3 (y_s[3])
    );

    // Flag whether the merger altered this line.
    always_comb begin
        line_diff_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (x_s[k] != y_s[k]) begin
                line_diff_s = 1'b1;
            end else begin
                line_diff_s = line_diff_s;
            end
        end
    end

    l2048_spawn_picker u_picker (
        .board (board_s),
        .start (bus.rnd[3:0]),
        .found (found_s),
        .idx   (spawn_idx_s)
    );

`ifdef L2048_FOUR_TILE_EN
    // Spawn a "4" tile on one selector value in sixteen.
    always_comb begin
        if (bus.rnd[7:4] == 4'd0) begin
            spawn_val_s = {{(TILE_W-2){1'b0}}, 2'd2};
        end else begin
            spawn_val_s = {{(TILE_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_rnd_s;
    assign unused_rnd_s = ^bus.rnd[7:4];
    assign spawn_val_s  = {{(TILE_W-1){1'b0}}, 1'b1};
`endif

    // Control FSM, board storage and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SEED0;
            line_idx_r  <= 2'd0;
            dir_r       <= LEFT;
            change_r    <= 1'b0;
            cells_r     <= '{default: {TILE_W{1'b0}}};
            busy_r      <= 1'b1;
            move_done_r <= 1'b0;
            moved_r     <= 1'b0;
        end else begin
            move_done_r <= 1'b0;
            case (state_r)
                SEED0, SEED1: begin
                    if (found_s) begin
                        cells_r[spawn_idx_s] <= spawn_val_s;
                    end
                    if (state_r == SEED0) begin
                        state_r <= SEED1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.move_valid) begin
                        dir_r      <= dir_t'(bus.move_dir);
                        change_r   <= 1'b0;
                        line_idx_r <= 2'd0;
                        busy_r     <= 1'b1;
                        state_r    <= LINE;
                    end
                end
                LINE: begin
                    cells_r[gidx_s[0]] <= y_s[0];
                    cells_r[gidx_s[1]] <= y_s[1];
                    cells_r[gidx_s[2]] <= y_s[2];
                    cells_r[gidx_s[3]] <= y_s[3];
                    if (line_diff_s) begin
                        change_r <= 1'b1;
                    end
                    line_idx_r <= line_idx_r + 2'd1;
                    if (line_idx_r == 2'd3) begin
                        state_r <= SPAWN;
                    end
                end
                SPAWN: begin
                    if (change_r && found_s) begin
                        cells_r[spawn_idx_s] <= spawn_val_s;
                    end
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    move_done_r <= 1'b1;
                    moved_r     <= change_r;
                end
                default: begin
                    state_r <= SEED0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.board     = board_s;
    assign bus.busy      = busy_r;
    assign bus.move_done = move_done_r;
    assign bus.moved     = moved_r;

endmodule

// File: tb/tb_logic2048_board_move.sv
// Directed bench for logic2048_board_move: seeding, merges in all slide
// directions, no-change moves, dropped requests and mid-move reset.
module tb_logic2048_board_move;
    import l2048_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    logic2048_board_move_if bif();

    logic2048_board_move dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bif.move_done === 1'b1) n_done++;
    end

    // Issue one move at a negedge while idle; observe 16 cycles after acceptance.
    task automatic run_move(input logic [1:0] d, input logic [7:0] r, input bit inject,
                            output int lat, output logic mv, output bit busy_ok);
        lat = -1; mv = 1'bx; busy_ok = 1'b1;
        bif.move_valid = 1'b1; bif.move_dir = d; bif.rnd = r;
        @(negedge clk);
        bif.move_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k < 5 && bif.busy !== 1'b1) busy_ok = 1'b0;
            if (k == 5 && bif.busy !== 1'b0) busy_ok = 1'b0;
            if (bif.move_done === 1'b1 && lat < 0) begin lat = k; mv = bif.moved; end
            if (inject && k == 2) begin bif.move_valid = 1'b1; bif.move_dir = 2'd0; end
            else bif.move_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst = 1'b1; bif.rnd = r;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n0;
        @(negedge clk);
        rst = 1'b1; bif.rnd = 8'h50;
        @(negedge clk);
        n_checks++; if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", bif.busy); end
        n_checks++; if (bif.board !== 64'h0) begin n_fail++; $display("FAIL reset_board: got %h expected 0", bif.board); end
        n_checks++; if (bif.move_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bif.move_done); end
        n_checks++; if (bif.moved !== 1'b0) begin n_fail++; $display("FAIL reset_moved: got %b expected 0", bif.moved); end
        rst = 1'b0; n0 = n_done;
        @(negedge clk);
        n_checks++; if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL seed1_busy: got %b expected 1", bif.busy); end
        @(negedge clk);
        n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL seed_busy_fall: got %b expected 0", bif.busy); end
        n_checks++; if (bif.board !== 64'h0000_0000_0000_0011) begin n_fail++; $display("FAIL seed_board: got %h expected %h", bif.board, 64'h11); end
        @(negedge clk);
        n_checks++; if (n_done != n0) begin n_fail++; $display("FAIL seed_no_done: got %0d pulses expected 0", n_done - n0); end
    endtask

    task automatic test_left_merge();
        int lat; logic mv; bit bok;
        run_move(2'd0, 8'h50, 1'b0, lat, mv, bok);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL left_latency: got %0d expected 5", lat); end
        n_checks++; if (mv !== 1'b1) begin n_fail++; $display("FAIL left_moved: got %b expected 1", mv); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL left_busy_window: got bad expected busy over E1..E4"); end
        n_checks++; if (bif.board !== 64'h0000_0000_0000_0012) begin n_fail++; $display("FAIL left_board: got %h expected %h", bif.board, 64'h12); end
        n_checks++; if (bif.moved !== 1'b1) begin n_fail++; $display("FAIL left_moved_hold: got %b expected 1", bif.moved); end
    endtask

    task automatic test_no_change();
        int lat; logic mv; bit bok; int n0;
        n0 = n_done;
        run_move(2'd0, 8'h50, 1'b0, lat, mv, bok);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL nochg_latency: got %0d expected 5", lat); end
        n_checks++; if (mv !== 1'b0) begin n_fail++; $display("FAIL nochg_moved: got %b expected 0", mv); end
        n_checks++; if (bif.board !== 64'h0000_0000_0000_0012) begin n_fail++; $display("FAIL nochg_board: got %h expected %h", bif.board, 64'h12); end
        n_checks++; if (n_done - n0 != 1) begin n_fail++; $display("FAIL nochg_pulses: got %0d expected 1", n_done - n0); end
    endtask

    task automatic test_right_spawn();
        int lat; logic mv; bit bok; logic [63:0] exp_b;
`ifdef L2048_FOUR_TILE_EN
        exp_b = 64'h2000_0000_0000_1200;
`else
        exp_b = 64'h1000_0000_0000_1200;
`endif
        run_move(2'd1, 8'h0F, 1'b0, lat, mv, bok);
        n_checks++; if (mv !== 1'b1) begin n_fail++; $display("FAIL right_moved: got %b expected 1", mv); end
        n_checks++; if (bif.board !== exp_b) begin n_fail++; $display("FAIL right_board: got %h expected %h", bif.board, exp_b); end
    endtask

    task automatic test_down_merge();
        int lat; logic mv; bit bok;
        logic [1:0]  dirs [0:3] = '{2'd0, 2'd0, 2'd0, 2'd0};
        logic [7:0]  rnds [0:3] = '{8'h19, 8'h19, 8'h15, 8'h10};
        logic [63:0] exps [0:3] = '{64'h0002_0010_0000_0000, 64'h0002_0011_0000_0000,
                                    64'h0002_0002_0010_0000, 64'h0002_0002_0001_0001};
        do_reset(8'h1C);
        n_checks++; if (bif.board !== 64'h0011_0000_0000_0000) begin n_fail++; $display("FAIL build_seed: got %h expected %h", bif.board, 64'h0011_0000_0000_0000); end
        for (int s = 0; s < 4; s++) begin
            run_move(dirs[s], rnds[s], 1'b0, lat, mv, bok);
            n_checks++; if (bif.board !== exps[s]) begin n_fail++; $display("FAIL build_step%0d: got %h expected %h", s, bif.board, exps[s]); end
        end
        run_move(2'd3, 8'h11, 1'b0, lat, mv, bok);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL down_latency: got %0d expected 5", lat); end
        n_checks++; if (mv !== 1'b1) begin n_fail++; $display("FAIL down_moved: got %b expected 1", mv); end
        n_checks++; if (bif.board !== 64'h0003_0002_0000_0010) begin n_fail++; $display("FAIL down_board: got %h expected %h", bif.board, 64'h0003_0002_0000_0010); end
    endtask

    task automatic test_busy_drop();
        int lat; logic mv; bit bok; int n0;
        n0 = n_done;
        run_move(2'd1, 8'h12, 1'b1, lat, mv, bok);
        n_checks++; if (bif.board !== 64'h3000_2000_0000_1100) begin n_fail++; $display("FAIL drop_board: got %h expected %h", bif.board, 64'h3000_2000_0000_1100); end
        n_checks++; if (n_done - n0 != 1) begin n_fail++; $display("FAIL drop_pulses: got %0d expected 1", n_done - n0); end
        n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got busy %b expected 0", bif.busy); end
    endtask

    task automatic test_reset_mid_move();
        int n0;
        bif.move_valid = 1'b1; bif.move_dir = 2'd0; bif.rnd = 8'h50;
        @(negedge clk);
        bif.move_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bif.board !== 64'h0) begin n_fail++; $display("FAIL midrst_board: got %h expected 0", bif.board); end
        n_checks++; if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", bif.busy); end
        n_checks++; if (bif.move_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bif.move_done); end
        rst = 1'b0; n0 = n_done;
        repeat (2) @(negedge clk);
        n_checks++; if (bif.board !== 64'h0000_0000_0000_0011) begin n_fail++; $display("FAIL midrst_reseed: got %h expected %h", bif.board, 64'h11); end
        repeat (8) @(negedge clk);
        n_checks++; if (n_done != n0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", n_done - n0); end
    endtask

    initial begin
        bif.move_valid = 1'b0;
        bif.move_dir   = 2'd0;
        bif.rnd        = 8'h50;
        test_reset();
        test_left_merge();
        test_no_change();
        test_right_spawn();
        test_down_merge();
        test_busy_drop();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic2048_board_move.md
# logic2048_board_move

Sequential 4x4 board engine directly upstream of `logic2048SingleLine`. It holds the game board, and on each move command it gathers the four lines in the chosen direction. Each line goes through `logic2048SingleLine`, one line per cycle, and the result is scattered back to the board. If anything changed, it then spawns a new tile. It sits between the button/direction decoder and the display renderer.

## Interface
- `TILE_W`, default 4: tile width; each tile holds a log2 exponent, 0 = empty.
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `move_valid` in 1: move request; sampled only when `busy`=0.
- `move_dir` in 2: 0 left, 1 right, 2 up, 3 down.
- `rnd` in 8: free-running random bits.
  - `rnd[3:0]` is the spawn start index.
  - `rnd[7:4]` is the tile-value selector.
- `board` out 64: cell i = row*4+col (row 0 top) at `board[4i+3:4i]`. Registered.
- `busy` out 1: high while seeding, processing lines, or spawning.
- `move_done` out 1: one-cycle pulse when a move completes.
- `moved` out 1: valid while `move_done`=1; high if the board changed. Holds its value until the next move.

## Operation
- FSM states: SEED0, SEED1, IDLE, LINE, SPAWN.
- Reset:
  - board = 0, state = SEED0, line_idx = 0.
  - `busy`=1, `move_done`=0, `moved`=0.
- SEED0/SEED1: each spawns one tile (spawn rule below), then advances. SEED1 goes to IDLE. `move_done` does not pulse after seeding.
- IDLE: `move_valid`=1 latches `move_dir`, clears the internal change flag, sets line_idx = 0 and enters LINE.
- LINE (4 cycles, line_idx 0..3): gather slots x0..x3, where slot 0 is the destination end.
  - left: row k, cols 0,1,2,3.
  - right: row k, cols 3,2,1,0.
  - up: col k, rows 0,1,2,3.
  - down: col k, rows 3,2,1,0.
  - `logic2048SingleLine` output y0..y3 is written back to the same cells.
  - If y differs from x, the change flag is set.
  - Leave LINE after line_idx = 3.
- SPAWN:
  - If the change flag is set, write a new tile at the first empty cell, scanning from `rnd[3:0]` upward and wrapping 15 to 0. An empty cell always exists after a change.
  - If the change flag is clear, the board is untouched.
  - Go to IDLE, pulse `move_done`, and drive `moved` = change flag.
- A spawn in SEED with a full board cannot occur, because it starts from empty.
- Tile value is 1, except as described under Configuration.
- No merge arithmetic happens here; exponent saturation belongs to the merger.
- `move_valid` while `busy`=1 is dropped, not queued.
- `rst` in any state aborts immediately. A partially processed board is discarded.

## Timing
- Move accepted on clock edge E0, when state is IDLE and `move_valid`=1.
- Lines 0..3 are written at E1..E4.
- Spawn is written at E5, which is also the edge where `move_done` and `moved` are registered.
- `busy` is high from after E0 through the cycle before E5. `move_done`=1 for exactly the cycle after E5.
- A new move can be accepted at E6.
- After `rst` deasserts, `busy` falls 2 edges later, at the end of SEED1.
- Merger path: gather mux → `logic2048SingleLine` → scatter, all in one cycle.

## Configuration
- `L2048_FOUR_TILE_EN`:
  - Defined: spawn value is 2 (tile "4") when `rnd[7:4]`==0, else 1.
  - Undefined: spawn value is always 1; `rnd[7:4]` is ignored.

## Structure
- Package `l2048_pkg` holds:
  - the `dir_t` enum (LEFT/RIGHT/UP/DOWN);
  - the `state_t` enum;
  - `TILE_W` and `N_CELLS`=16;
  - the function `cell_idx(dir, line, slot)` returning 0..15.
- Sub-module `l2048_spawn_picker`:
  - combinational;
  - inputs: board and start index;
  - outputs: found flag and cell index (first empty cell, wrapping).
- `logic2048SingleLine` is instantiated once.

## Test plan
- Reset with `rnd`=8'h50 → after 2 edges, cell0=1, cell1=1, all other cells 0; `busy`=0; no `move_done` pulse.
- From that board, left with `rnd`=8'h50 → row0 becomes [2,1,0,0] (merge, then spawn at cell1). `move_done` pulses on cycle 6 with `moved`=1.
- Board with row0 [2,1,0,0], all else empty, left → board unchanged, `moved`=0, `move_done` still pulses.
- Same board, right with `rnd`=8'h0F → row0 becomes [0,0,2,1] and spawn lands at cell15 (value 1 without the macro, value 2 with it). `moved`=1.
- Column 0 = [1,1,2,2] top to bottom, down → column 0 = [0,0,2,3] top to bottom; `moved`=1.
- Assert `move_valid` during LINE → ignored. Assert `rst` at E2 of a move → board cleared, state re-seeds, no `move_done` pulse.
